// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit:
// R-type funct encodings and controller states.
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for multiply,
// restoring shift-subtract for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, m};
        if (is_div) begin
            // diff[WIDTH] set means the trial subtract borrowed: restore.
            nxt_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers and start/busy/done
// handshake; mul/div take WIDTH+2 cycles from start to done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_t state, state_next;

    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   acc_hi, acc_lo, mcand;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic               op_div, sign_a, sign_b, div_zero;
    logic               is_muldiv, is_signed, is_div_funct, accept;

    assign is_muldiv    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                          (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign is_signed    = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign is_div_funct = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign accept       = start && (state == IDLE) && is_muldiv;

    assign busy = (state != IDLE);

    always_comb begin
        result = '0;
        if (funct == FUNCT_MFHI) begin
            result = hi;
        end else if (funct == FUNCT_MFLO) begin
            result = lo;
        end
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div(op_div),
        .acc_hi(acc_hi),
        .acc_lo(acc_lo),
        .m     (mcand),
        .nxt_hi(step_hi),
        .nxt_lo(step_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (count == CNT_W'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign correction of the unsigned magnitude result.
    always_comb begin
        prod_raw = {acc_hi, acc_lo};
        prod_fix = (sign_a ^ sign_b) ? -prod_raw : prod_raw;
        if (op_div) begin
            // Divide by zero leaves |a| in the remainder, so hi restores a.
            fix_lo = div_zero ? '1 : ((sign_a ^ sign_b) ? -acc_lo : acc_lo);
            fix_hi = sign_a ? -acc_hi : acc_hi;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mcand    <= '0;
            op_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_a   <= is_signed && a[WIDTH-1];
                        sign_b   <= is_signed && b[WIDTH-1];
                        acc_lo   <= (is_signed && a[WIDTH-1]) ? -a : a;
                        mcand    <= (is_signed && b[WIDTH-1]) ? -b : b;
                        acc_hi   <= '0;
                        op_div   <= is_div_funct;
                        div_zero <= (b == '0);
                        count    <= CNT_W'(WIDTH);
                    end else if (start && (funct == FUNCT_MTHI)) begin
                        hi <= a;
                    end else if (start && (funct == FUNCT_MTLO)) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count - CNT_W'(1);
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers; next-generation companion to the ALU decoder.
- Decodes R-type funct codes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Executes multiply/divide over WIDTH+2 cycles with a start/busy/done handshake; the controller stalls the pipeline on busy.
- Width-parametrised; default is the 32-bit MIPS datapath.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request strobe, qualified by funct
- funct  in  6  R-type funct field
- a  in  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo data)
- b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  high while a multiply/divide is in flight
- done  out  1  one-cycle pulse when HI/LO hold a new mul/div result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- result  out  WIDTH  mfhi -> hi, mflo -> lo, else 0 (combinational on funct)

Behaviour:
- Reset (async, any state): state=IDLE; hi=lo=0; busy=0; done=0; counter=0; internal accumulators=0. An in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE, start=1, funct in {MULT,MULTU,DIV,DIVU} (cycle T):
  - latch operand magnitudes (signed ops) or raw values (unsigned ops);
  - latch sign flags; counter=WIDTH; go to RUN.
- RUN (T+1..T+WIDTH):
  - one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide;
  - counter decrements; at counter==1 go to FIX.
- FIX (T+WIDTH+1):
  - apply sign correction; write hi/lo at the end of the cycle; go to IDLE.
  - done=1 during cycle T+WIDTH+2 only.
- busy=1 exactly in cycles T+1..T+WIDTH+1; busy=0 in IDLE.
- Multiply: {hi,lo} = full 2*WIDTH-bit product. Signed product is negated (two's complement over 2*WIDTH) when sign(a) xor sign(b).
- Divide (b != 0):
  - lo = quotient, truncated toward zero;
  - hi = remainder, taking the sign of the dividend.
  - MIN/-1 signed gives lo=MIN, hi=0.
- Divide by zero (signed or unsigned): lo = all ones, hi = a (original raw value). No exception is raised; latency is unchanged.
- MTHI/MTLO in IDLE with start=1: hi (resp. lo) = a at that clock edge; done stays 0; state stays IDLE.
- start while busy (any funct): ignored. No effect on operands, hi/lo or timing.
- start with a non-muldiv funct, or MFHI/MFLO: no state change.
- result is valid in any state, including busy. During busy it reflects the old hi/lo.
- Back-to-back: a new start is accepted in the same cycle done=1, since the state is IDLE.

Decomposition:
- Package muldiv_pkg holds:
  - funct constants: FUNCT_MFHI=6'b010000, FUNCT_MTHI=6'b010001, FUNCT_MFLO=6'b010010, FUNCT_MTLO=6'b010011, FUNCT_MULT=6'b011000, FUNCT_MULTU=6'b011001, FUNCT_DIV=6'b011010, FUNCT_DIVU=6'b011011;
  - state enum muldiv_state_t {IDLE, RUN, FIX}.
- One natural sub-module: muldiv_step, a combinational single-iteration datapath (add-or-pass for multiply, trial-subtract for divide). The top keeps the FSM, counter, sign handling and the HI/LO registers.

Test Plan (WIDTH=32, start pulsed at cycle T):
- MULT a=-3 (FFFFFFFD), b=5 -> busy T+1..T+33; done at T+34; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then mfhi funct gives result=FFFFFFFE.
- DIV a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=00000010, b=0 -> lo=FFFFFFFF, hi=00000010, done at T+34.
- During a MULT, pulse start with DIV and with MTHI a=1234 at T+5 -> both ignored; final hi/lo equal the MULT result.
- Assert reset at T+10 of a DIV -> busy, done, hi, lo go to 0 immediately. After release, MTLO a=AB then MULT 6*7 -> lo=0000002A, hi=0.
